sfp_mul_sched: RTL and testbench
================================

# sfp_mul_sched

Round-robin scheduler that shares one pipelined full-precision signed fixed-point multiplier between N requesters, such as ray/plane intersection and shading units. It accepts at most one operand pair per cycle using valid/ready handshakes. Each issued operation carries its requester index through a valid/tag pipeline, and the product returns to the originating requester after a fixed latency. The block sits between the per-unit datapaths and the shared multiplier resource in the math core.

## Interface
- N, default 4: number of requesters; must be ≥2. Elaboration `$error` otherwise.
- LAT, default 2: multiplier latency in cycles, counted from issue to result; must be ≥1. Elaboration `$error` otherwise.
- IW1, default 4, and QW1, default 12: integer and fraction bits of operand a.
- IW2, default 4, and QW2, default 12: integer and fraction bits of operand b.
- Derived W1 = IW1+QW1, W2 = IW2+QW2, WO = W1+W2, IDW = max(1, $clog2(N)). The result format is IO = IW1+IW2 and QO = QW1+QW2 (full width).
- clk  in  1  single clock for the whole block.
- rst  in  1  reset; **asynchronous, active-high**.
- req_valid  in  N  requester i has an operand pair pending.
- req_ready  out  N  one-hot or zero; a bit is set when requester i is granted this cycle.
- req_a  in  N×W1  signed operand a, per requester.
- req_b  in  N×W2  signed operand b, per requester.
- res_valid  out  N  one-hot or zero; the result for requester i is on res_val this cycle.
- res_val  out  WO  signed product, shared bus.
- res_id  out  IDW  index of the requester owning res_val.
- inflight  out  $clog2(LAT+1)  number of operations issued but not yet returned.

## Operation
- **Handshake:** an issue to requester i occurs when req_valid[i] and req_ready[i] are both high at a clk rising edge.
- **req_ready:** combinational from req_valid, the round-robin pointer and rst.
  - It is forced to 0 while rst is high.
  - A requester may not drop req_valid, or change req_a/req_b, until it has been granted.
- **Arbitration:** pointer ptr has IDW bits and resets to 0.
  - The grant goes to the first i with req_valid[i] set, scanning cyclically from ptr.
  - After a grant to i, ptr becomes (i+1) mod N.
  - With no valid request, no grant is made and ptr holds.
  - The bench checks fairness: with all N requesters continuously valid, grants follow 0,1,…,N-1,0,…
- **Arithmetic:** the product is the signed full-width product of a and b.
  - No rounding, truncation or saturation; the result is exact.
  - The sign of each operand is extended internally.
- **Pipeline:** LAT stages, each holding {valid, id, partial/product}.
  - The product is registered in stage 1; later stages only delay it.
  - There is no stall and no result backpressure. A requester must consume its result in the cycle res_valid is asserted.
- **Outputs:** res_valid[res_id] equals the last-stage valid. res_val and res_id hold their previous value when the last stage is invalid.
- **inflight counter:** +1 on an issue, −1 on a retire, unchanged when both happen in the same cycle.
  - Its maximum is LAT.
  - Overflow and underflow are impossible by construction; an assertion checks both.
- **Reset mid-operation:** all in-flight operations are discarded with no result emitted. The pointer returns to 0.

## Timing
- Reset values: req_ready=0, res_valid=0, res_val=0, res_id=0, inflight=0, ptr=0, all stage valids 0.
- Latency: an issue at edge t gives res_valid high for exactly the cycle following edge t+LAT-1, i.e. LAT cycles after the request cycle.
- Throughput: 1 issue per cycle, sustained indefinitely.
- Ordering: results are in issue order. Back-to-back issues give back-to-back results.
- Simultaneous issue and retire in the same cycle: both take effect, and inflight is unchanged.
- Grant and issue take 0 cycles: the grant is visible in the same cycle as req_valid when the request wins.

## Structure
- Package sfp_sched_pkg holds:
  - the IDW/WO width helper functions;
  - the stage record typedef {valid, id, prod} (parameterized through localparams in the module).
- Sub-module rr_arbiter, parameterized by N, is purely combinational apart from its ptr register:
  - inputs: req, advance;
  - outputs: one-hot gnt, gnt_idx.
- The multiplier stage is inline: `assign` of the signed product into the stage-1 register.

## Test plan
- **Single op:** IW=QW=4 for both operands, requester 2 issues a=24 (1.5) and b=36 (2.25). Required response:
  - res_valid=4'b0100 exactly LAT cycles later;
  - res_val=864 (3.375 in Q8.8);
  - res_id=2.
- **Signed:** a=-24 (-1.5), b=32 (2.0). Required response: res_val=16'hFD00 (-3.0), with sign correct at the full width.
- **Fairness:** all 4 requesters continuously valid for 12 cycles. Required response:
  - grant order 0,1,2,3 repeated three times;
  - results return in the same order with the matching id;
  - inflight saturates at LAT.
- **Sparse contention:** only requesters 1 and 3 valid, starting with ptr=0. Required response: grants 1,3,1,3; ptr skips the idle requesters.
- **Reset mid-flight:** issue 2 operations, then assert rst asynchronously between clock edges. Required response:
  - all outputs read 0 immediately;
  - no result ever emerges;
  - after release, the first grant goes to the lowest valid index.
- **Idle:** no req_valid for 10 cycles. Required response: req_ready=0, res_valid=0, inflight=0, and ptr unchanged.

Source files
------------

// File: rtl/sfp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sfp_sched_pkg
// Purpose : Shared width helpers for the multiplier scheduler.
//           calc_idw(n)      -> requester index width, never below 1 bit
//           calc_wo(w1, w2)  -> full-precision product width
//           The stage record {valid, id, prod} depends on module parameters,
//           so it is declared as a typedef inside sfp_mul_sched using the
//           widths these helpers produce.
// Revision: 1.0 - initial release
// ============================================================================
package sfp_sched_pkg;

    function automatic int calc_idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_wo(input int w1, input int w2);
        return w1 + w2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin arbiter. Scans req cyclically starting at the pointer
//           and grants the first set bit. The pointer moves to one past the
//           granted index whenever the grant is consumed (advance).
// Ports   : clk, rst      clock, asynchronous active-high reset
//           req[N]        request vector
//           advance       grant was taken this cycle; move the pointer
//           gnt[N]        one-hot grant (zero when nothing requests)
//           gnt_idx       index of the granted requester
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sfp_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req,
    input  logic                     advance,
    output logic [N-1:0]             gnt,
    output logic [calc_idw(N)-1:0]   gnt_idx
);

    localparam int IDW = calc_idw(N);

    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   w_gnt;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_cand;
    logic           w_found;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                w_gnt[w_cand] = 1'b1;
                w_idx         = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_idx == IDW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign gnt     = w_gnt;
    assign gnt_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/sfp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module  : sfp_mul_sched
// Purpose : Shares one pipelined signed fixed-point multiplier between N
//           requesters. One operand pair is accepted per cycle by round-robin
//           grant; the requester index travels with the operation through a
//           LAT-deep {valid, id, prod} pipeline and the exact full-width
//           product returns to its owner LAT cycles after issue.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           req_valid[N]  requester has an operand pair pending
//           req_ready[N]  one-hot grant, combinational, zero during reset
//           req_a, req_b  packed per-requester signed operands
//           res_valid[N]  one-hot result strobe for the owning requester
//           res_val       signed product, Q(IW1+IW2).(QW1+QW2)
//           res_id        owner of res_val
//           inflight      operations issued and not yet returned
// Revision: 1.0 - initial release
// ============================================================================
module sfp_mul_sched
    import sfp_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int IW1 = 4,
    parameter int QW1 = 12,
    parameter int IW2 = 4,
    parameter int QW2 = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      req_valid,
    output logic [N-1:0]                      req_ready,
    input  logic [N*(IW1+QW1)-1:0]            req_a,
    input  logic [N*(IW2+QW2)-1:0]            req_b,
    output logic [N-1:0]                      res_valid,
    output logic [calc_wo(IW1+QW1,IW2+QW2)-1:0] res_val,
    output logic [calc_idw(N)-1:0]            res_id,
    output logic [$clog2(LAT+1)-1:0]          inflight
);

    localparam int W1  = IW1 + QW1;
    localparam int W2  = IW2 + QW2;
    localparam int WO  = calc_wo(W1, W2);
    localparam int IDW = calc_idw(N);
    localparam int CW  = $clog2(LAT + 1);

    generate
        if (N < 2) begin : g_chk_n
            $error("sfp_mul_sched: N must be at least 2");
        end
        if (LAT < 1) begin : g_chk_lat
            $error("sfp_mul_sched: LAT must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic [WO-1:0]  prod;
    } stage_t;

    stage_t                r_stage [LAT];
    logic [CW-1:0]         r_inflight;

    logic [N-1:0]          w_gnt;
    logic [IDW-1:0]        w_gnt_idx;
    logic                  w_issue;
    logic                  w_retire;
    logic [W1-1:0]         w_a;
    logic [W2-1:0]         w_b;
    logic signed [WO-1:0]  w_a_ext;
    logic signed [WO-1:0]  w_b_ext;
    logic signed [WO-1:0]  w_prod;

    rr_arbiter #(
        .N       (N)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_issue),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = rst ? '0 : w_gnt;
    assign w_issue   = |(req_valid & req_ready);
    assign w_retire  = r_stage[LAT-1].valid;

    // One-hot AND-OR operand mux driven by the grant.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_a = req_a[i*W1 +: W1];
                w_b = req_b[i*W2 +: W2];
            end
        end
    end

    // Both operands sign-extended to the product width, so a WO x WO multiply
    // truncated to WO bits is the exact two's-complement product.
    assign w_a_ext = {{W2{w_a[W1-1]}}, w_a};
    assign w_b_ext = {{W1{w_b[W2-1]}}, w_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // id/prod load only alongside a valid, so the last stage naturally holds
    // the previous result while it is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0].valid <= w_issue;
            if (w_issue) begin
                r_stage[0].id   <= w_gnt_idx;
                r_stage[0].prod <= w_prod;
            end
            for (int s = 1; s < LAT; s++) begin
                r_stage[s].valid <= r_stage[s-1].valid;
                if (r_stage[s-1].valid) begin
                    r_stage[s].id   <= r_stage[s-1].id;
                    r_stage[s].prod <= r_stage[s-1].prod;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_comb begin
        res_valid = '0;
        if (r_stage[LAT-1].valid) begin
            res_valid[r_stage[LAT-1].id] = 1'b1;
        end
    end

    assign res_val  = r_stage[LAT-1].prod;
    assign res_id   = r_stage[LAT-1].id;
    assign inflight = r_inflight;

    // A full pipeline always retires, so the count can never leave [0, LAT].
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_issue && !w_retire && (r_inflight == CW'(LAT))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(w_retire && !w_issue && (r_inflight == '0)));

endmodule
`default_nettype wire

// File: tb/tb_sfp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sfp_mul_sched
// Purpose : Self-checking bench for sfp_mul_sched (N=4, LAT=3, Q4.4 x Q4.4).
//           Grants are checked inline per scenario; expected results are
//           queued at grant time and popped by a result monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sfp_mul_sched;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IW1 = 4;
    localparam int QW1 = 4;
    localparam int IW2 = 4;
    localparam int QW2 = 4;
    localparam int W1  = IW1 + QW1;
    localparam int W2  = IW2 + QW2;
    localparam int WO  = W1 + W2;
    localparam int IDW = 2;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W1-1:0]   req_a = '0;
    logic [N*W2-1:0]   req_b = '0;
    logic [N-1:0]      res_valid;
    logic [WO-1:0]     res_val;
    logic [IDW-1:0]    res_id;
    logic [CW-1:0]     inflight;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [WO-1:0]  val;
        int             due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [N-1:0]  mon_ev;

    sfp_mul_sched #(
        .N   (N),
        .LAT (LAT),
        .IW1 (IW1),
        .QW1 (QW1),
        .IW2 (IW2),
        .QW2 (QW2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_val   (res_val),
        .res_id    (res_id),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [WO-1:0] model_mul(input logic [W1-1:0] a, input logic [W2-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[WO-1:0];
    endfunction

    task automatic refresh(input int i);
        req_a[i*W1 +: W1] = W1'($urandom);
        req_b[i*W2 +: W2] = W2'($urandom);
    endtask

    // Grant observed before edge cyc+1; result due after edge cyc+LAT.
    task automatic push_exp(input int id, input logic [WO-1:0] v);
        exp_t e;
        e.id  = IDW'(id);
        e.val = v;
        e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    // Result monitor: samples registered outputs 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_result: id=%0d due cycle %0d, nothing by cycle %0d",
                     sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (res_valid !== '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: res_valid=%b res_id=%0d res_val=%h, required no result",
                         res_valid, res_id, res_val);
            end else begin
                mon_e  = sb.pop_front();
                mon_ev = '0;
                mon_ev[mon_e.id] = 1'b1;
                if (res_valid !== mon_ev || res_id !== mon_e.id || res_val !== mon_e.val
                    || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL result: res_valid=%b id=%0d val=%h cycle=%0d, required %b id=%0d val=%h cycle=%0d",
                             res_valid, res_id, res_val, cyc, mon_ev, mon_e.id, mon_e.val, mon_e.due);
                end
            end
        end
    end

    task automatic test_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) refresh(i);
        @(negedge clk); #1;
        checks++;
        if ({req_ready, res_valid, res_val, res_id, inflight} !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b res_valid=%b val=%h id=%0d inflight=%0d, required all 0",
                     req_ready, res_valid, res_val, res_id, inflight);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== '0 || res_valid !== '0 || inflight !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b res_valid=%b inflight=%0d, required 0",
                     req_ready, res_valid, inflight);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_a[2*W1 +: W1] = 8'd24;
        req_b[2*W2 +: W2] = 8'd36;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, required 0100", req_ready);
        end
        push_exp(2, 16'd864);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (inflight !== 2'd1) begin
            errors++;
            $display("FAIL single_inflight: inflight=%0d, required 1", inflight);
        end
        repeat (LAT + 1) @(negedge clk);
        #1;
        checks++;
        if (inflight !== '0 || res_valid !== '0) begin
            errors++;
            $display("FAIL single_drain: inflight=%0d res_valid=%b, required 0",
                     inflight, res_valid);
        end
    endtask

    task automatic test_idle();
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== '0 || res_valid !== '0 || inflight !== '0) begin
                errors++;
                $display("FAIL idle k=%0d: ready=%b res_valid=%b inflight=%0d, required 0",
                         k, req_ready, res_valid, inflight);
            end
        end
    endtask

    // Pointer was left at 3 by the single op; holding through idle means
    // requester 3 beats requester 0 here.
    task automatic test_signed();
        @(negedge clk);
        req_a[3*W1 +: W1] = 8'hE8;
        req_b[3*W2 +: W2] = 8'h20;
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL signed_grant_ptr_held: req_ready=%b, required 1000", req_ready);
        end
        push_exp(3, 16'hFD00);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL signed_wrap_grant: req_ready=%b, required 0001", req_ready);
        end
        push_exp(0, model_mul(req_a[0 +: W1], req_b[0 +: W2]));
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 1) @(negedge clk);
        #1;
        checks++;
        if (inflight !== '0) begin
            errors++;
            $display("FAIL signed_drain: inflight=%0d, required 0", inflight);
        end
    endtask

    // Pointer starts at 1 after the signed test.
    task automatic test_fairness();
        int            last_g;
        int            g;
        logic [N-1:0]  exp_rdy;
        last_g = -1;
        req_a[1*W1 +: W1] = 8'h80; req_b[1*W2 +: W2] = 8'h80;
        req_a[2*W1 +: W1] = 8'h7F; req_b[2*W2 +: W2] = 8'h80;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (last_g >= 0) refresh(last_g);
            req_valid = '1;
            #1;
            g = (1 + k) % N;
            exp_rdy = '0;
            exp_rdy[g] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fair_grant k=%0d: req_ready=%b, required %b", k, req_ready, exp_rdy);
            end
            push_exp(g, model_mul(req_a[g*W1 +: W1], req_b[g*W2 +: W2]));
            last_g = g;
            if (k >= LAT) begin
                checks++;
                if (inflight !== CW'(LAT)) begin
                    errors++;
                    $display("FAIL fair_inflight k=%0d: inflight=%0d, required %0d", k, inflight, LAT);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 1) @(negedge clk);
        #1;
        checks++;
        if (inflight !== '0) begin
            errors++;
            $display("FAIL fair_drain: inflight=%0d, required 0", inflight);
        end
    endtask

    // Pointer is 1 on entry; two ops issue, then reset lands before either
    // reaches the last stage.
    task automatic test_reset_midflight();
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant0: req_ready=%b, required 0010", req_ready);
        end
        push_exp(1, model_mul(req_a[1*W1 +: W1], req_b[1*W2 +: W2]));
        @(negedge clk);
        refresh(1);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_grant1: req_ready=%b, required 0001", req_ready);
        end
        push_exp(0, model_mul(req_a[0 +: W1], req_b[0 +: W2]));
        @(negedge clk);
        #1;
        checks++;
        if (inflight !== 2'd2) begin
            errors++;
            $display("FAIL mid_inflight: inflight=%0d, required 2", inflight);
        end
        req_valid = 4'b1100;
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({req_ready, res_valid, res_val, res_id, inflight} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: ready=%b res_valid=%b val=%h id=%0d inflight=%0d, required all 0",
                     req_ready, res_valid, res_val, res_id, inflight);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL mid_first_grant: req_ready=%b, required 0100", req_ready);
        end
        push_exp(2, model_mul(req_a[2*W1 +: W1], req_b[2*W2 +: W2]));
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 1) @(negedge clk);
        #1;
        checks++;
        if (inflight !== '0) begin
            errors++;
            $display("FAIL mid_drain: inflight=%0d, required 0", inflight);
        end
    endtask

    task automatic test_sparse();
        int            last_g;
        int            g;
        logic [N-1:0]  exp_rdy;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_g = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (last_g >= 0) refresh(last_g);
            req_valid = 4'b1010;
            #1;
            g = (k % 2 == 0) ? 1 : 3;
            exp_rdy = '0;
            exp_rdy[g] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sparse_grant k=%0d: req_ready=%b, required %b", k, req_ready, exp_rdy);
            end
            push_exp(g, model_mul(req_a[g*W1 +: W1], req_b[g*W2 +: W2]));
            last_g = g;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 1) @(negedge clk);
        #1;
        checks++;
        if (inflight !== '0) begin
            errors++;
            $display("FAIL sparse_drain: inflight=%0d, required 0", inflight);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_idle();
        test_signed();
        test_fairness();
        test_reset_midflight();
        test_sparse();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d results outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
